// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg: shared types, constants and helpers for dual_port_ram.
//   state_t        : ST_INIT (clearing sweep) / ST_RUN (normal operation)
//   RDW_*          : same-port read-during-write selectors
//   merge_bytes    : byte-enable merge of write data into a stored word
//   even_parity    : even-parity bit of one byte
package dual_port_ram_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MAX_DW = 1024;
    localparam int MAX_BE = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] merge_bytes(
        input logic [MAX_DW-1:0] word,
        input logic [MAX_DW-1:0] wdata,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_DW-1:0] r;
        r = word;
        for (int i = 0; i < MAX_BE; i++)
            if (be[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
        return r;
    endfunction

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// dpram_rd_pipe: READ_LATENCY register stages for one port's {rdata, rvalid, err}.
//   clk, rst_n                 : clock, synchronous active-low reset (flushes stages)
//   in_valid, in_data, in_err  : read result sampled at the accepting edge
//   rdata, rvalid, err         : delayed result; rdata holds between valid beats
module dpram_rd_pipe
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] d1;
    logic                  v1, e1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1 <= '0;
            v1 <= 1'b0;
            e1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            e1 <= in_err;
            if (in_valid) d1 <= in_data;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_l2
            logic [DATA_WIDTH-1:0] d2;
            logic                  v2, e2;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    e2 <= e1;
                    if (v1) d2 <= d1;
                end
            end
            assign rdata  = d2;
            assign rvalid = v2;
            assign err    = e2;
        end else begin : g_l1
            assign rdata  = d1;
            assign rvalid = v1;
            assign err    = e1;
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram.sv
// dual_port_ram: true dual-port synchronous RAM with clearing sweep after reset.
//   clk, rst_n            : clock, synchronous active-low reset
//   {a,b}_cs/_we/_be      : port select, write enable, byte enables
//   {a,b}_addr/_wdata     : word address, write data
//   {a,b}_rdata/_rvalid   : registered read data (held) and one-cycle valid strobe
//   {a,b}_err             : out-of-range (or parity) error, aligned with rvalid
//   collision             : pulse one cycle after both ports write one address
//   init_busy             : high while the post-reset clearing sweep runs
// Optional: define DPRAM_PARITY_EN to store and check one even-parity bit per byte.
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_cs,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    output logic                    a_err,
    input  logic                    b_cs,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid,
    output logic                    b_err,
    output logic                    collision,
    output logic                    init_busy
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    state_t                state, state_nx;
    logic [IW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- FSM: register / next state / outputs ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_INIT) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = (state == ST_INIT && cnt == IW'(DEPTH - 1)) ? ST_RUN : state;
    end

    always_comb begin
        init_busy = (state == ST_INIT);
    end

    // ---------------- request decode ----------------
    // Requests at a reset edge are dropped so nothing commits while resetting.
    logic                  run;
    logic                  a_ok, b_ok, a_acc, b_acc, a_wr, b_wr, a_perr, b_perr;
    logic [IW-1:0]         a_idx, b_idx;
    logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, a_rd, b_rd;

    assign run   = rst_n && state == ST_RUN;
    assign a_ok  = 32'(a_addr) < DEPTH;
    assign b_ok  = 32'(b_addr) < DEPTH;
    assign a_idx = a_addr[IW-1:0];
    assign b_idx = b_addr[IW-1:0];
    assign a_acc = run & a_cs;
    assign b_acc = run & b_cs;
    assign a_wr  = a_acc & a_we & a_ok;
    assign b_wr  = b_acc & b_we & b_ok;

    // Array reads see pre-edge contents, so cross-port readers always get old data.
    assign a_old = a_ok ? mem[a_idx] : '0;
    assign b_old = b_ok ? mem[b_idx] : '0;
    assign a_new = DATA_WIDTH'(merge_bytes(MAX_DW'(a_old), MAX_DW'(a_wdata), MAX_BE'(a_be)));
    assign b_new = DATA_WIDTH'(merge_bytes(MAX_DW'(b_old), MAX_DW'(b_wdata), MAX_BE'(b_be)));
    assign a_rd  = !a_ok ? '0 : (a_we && RDW_MODE == RDW_WRITE_FIRST) ? a_new : a_old;
    assign b_rd  = !b_ok ? '0 : (b_we && RDW_MODE == RDW_WRITE_FIRST) ? b_new : b_old;

`ifdef DPRAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];

    function automatic logic par_bad(input logic [DATA_WIDTH-1:0] w, input logic [NB-1:0] p);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NB; i++)
            if (even_parity(w[i*8 +: 8]) != p[i]) bad = 1'b1;
        return bad;
    endfunction

    assign a_perr = a_ok && par_bad(mem[a_idx], par[a_idx]);
    assign b_perr = b_ok && par_bad(mem[b_idx], par[b_idx]);
`else
    assign a_perr = 1'b0;
    assign b_perr = 1'b0;
`endif

    // ---------------- array ----------------
    // Port B is written first so port A's later assignment wins on shared bytes,
    // while bytes enabled only on B still land.
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_INIT) begin
            mem[cnt] <= '0;
`ifdef DPRAM_PARITY_EN
            par[cnt] <= '0;
`endif
        end
        for (int i = 0; i < NB; i++) begin
            if (b_wr && b_be[i]) begin
                mem[b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
`ifdef DPRAM_PARITY_EN
                par[b_idx][i] <= even_parity(b_wdata[i*8 +: 8]);
`endif
            end
            if (a_wr && a_be[i]) begin
                mem[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
`ifdef DPRAM_PARITY_EN
                par[a_idx][i] <= even_parity(a_wdata[i*8 +: 8]);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) collision <= 1'b0;
        else        collision <= a_wr & b_wr & (a_addr == b_addr);
    end

    // ---------------- read pipelines ----------------
    dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (a_acc),
        .in_data  (a_rd),
        .in_err   (a_acc & (~a_ok | a_perr)),
        .rdata    (a_rdata),
        .rvalid   (a_rvalid),
        .err      (a_err)
    );

    dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (b_acc),
        .in_data  (b_rd),
        .in_err   (b_acc & (~b_ok | b_perr)),
        .rdata    (b_rdata),
        .rvalid   (b_rvalid),
        .err      (b_err)
    );

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
- Parametrised true dual-port synchronous RAM. Two independent ports A and B, each with chip select, write enable, byte enables, registered read data and a read-valid strobe.
- Successor to the single-port tristate RAM: separate rdata/wdata buses instead of a shared data bus.
- Adds configurable read latency, read-during-write mode, write-collision arbitration, and a post-reset clearing sweep.
- Sits between the core's load/store unit (port A) and the debug/DMA path (port B).

Parameters:
- ADDR_WIDTH, 4, address bits per port.
- DATA_WIDTH, 32, data bits per word; must be a multiple of 8.
- DEPTH, 16, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to rdata/rvalid; legal values are 1 or 2.
- RDW_MODE, 0, same-port read-during-write result; 0 = old data (read-first), 1 = new data (write-first).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- a_cs, b_cs  in  1  port select.
- a_we, b_we  in  1  write enable; qualified by cs.
- a_be, b_be  in  DATA_WIDTH/8  byte enables for writes.
- a_addr, b_addr  in  ADDR_WIDTH  word address.
- a_wdata, b_wdata  in  DATA_WIDTH  write data.
- a_rdata, b_rdata  out  DATA_WIDTH  read data; held between reads.
- a_rvalid, b_rvalid  out  1  one-cycle pulse marking valid rdata.
- a_err, b_err  out  1  one-cycle pulse, aligned with rvalid timing, on an out-of-range access.
- collision  out  1  one-cycle pulse when both ports write the same address.
- init_busy  out  1  high while the clearing sweep runs.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FSM goes to INIT and the init counter is set to 0.
  - rdata=0, rvalid=0, err=0, collision=0, init_busy=1.
  - Read pipelines are flushed.
  - Reset mid-operation aborts in-flight reads: no rvalid is emitted for them.
- FSM state INIT:
  - Writes 0 to mem[cnt] and increments cnt each cycle.
  - Port requests are ignored: no writes, no rvalid.
  - Moves to RUN after writing address DEPTH-1, so init_busy is high for exactly DEPTH cycles after reset release.
- FSM state RUN:
  - Stays in RUN until the next reset.
- Write (RUN, cs=1, we=1, addr<DEPTH):
  - Byte i of mem[addr] is updated when be[i]=1; other bytes are unchanged.
  - be=0 is a legal no-op.
- Read (RUN, cs=1, we=0, addr<DEPTH):
  - Array is sampled at edge N.
  - READ_LATENCY=1: rdata and rvalid are valid after edge N.
  - READ_LATENCY=2: one extra register stage, valid after edge N+1.
  - Back-to-back reads are fully pipelined, one per cycle per port.
- Same-port write with cs&we:
  - Also produces rdata/rvalid.
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged post-write word.
- Cross-port access, one port reads an address the other writes in the same cycle:
  - The reader gets the old data, regardless of RDW_MODE.
- Both ports write the same address in the same cycle:
  - Port A's byte-enabled bytes win.
  - Bytes enabled only on B are still written from B.
  - collision pulses one cycle later.
- Out-of-range address (addr>=DEPTH):
  - Write is dropped.
  - Read returns rdata=0 with rvalid=1 and err=1, at normal latency.
- cs=0: no access; rdata holds its last value and rvalid=0.

Optional Feature:
- Macro DPRAM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte, computed from wdata and be at write time.
  - The INIT sweep writes parity 0.
  - On read, parity is recomputed; any mismatch sets err=1 alongside rvalid, and rdata still returns the stored data.
- When undefined:
  - No parity storage.
  - err reflects only out-of-range accesses.

Decomposition:
- Package dual_port_ram_pkg holds:
  - state enum {ST_INIT, ST_RUN}.
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - Function for byte-merging wdata into a word under a be mask.
  - Parity function.
- Sub-module dpram_rd_pipe holds one port's READ_LATENCY register stages for {rdata, rvalid, err} with synchronous reset. It is instantiated once per port.

Test Plan:
- Reset, release, idle: init_busy stays high exactly 16 cycles; afterwards, reading every address returns 0x00000000 with rvalid.
- Write A addr 3 = 0xDEADBEEF with be=4'b1111, then be=4'b0001 data 0x00000011; read B addr 3 -> 0xDEADBE11, rvalid 1 cycle after the read (READ_LATENCY=1) or 2 cycles after (READ_LATENCY=2).
- Same cycle, A writes addr 5 = 0xAAAAAAAA with be=4'b0011 and B writes addr 5 = 0xBBBBBBBB with be=4'b1110 -> mem[5]=0xBBBBAAAA; collision pulses once.
- Same-port read-during-write of 0x12345678 over old 0x0 -> rdata 0x00000000 when RDW_MODE=0, 0x12345678 when RDW_MODE=1. Simultaneous B read of the same address -> 0x00000000.
- Read addr 20 with ADDR_WIDTH=5, DEPTH=16 -> rdata 0, rvalid=1, err=1. Write addr 20 -> no array change.
- Issue a read, assert rst_n=0 on the next edge -> no rvalid; init sweep restarts. With DPRAM_PARITY_EN, force-flip a stored bit, then read -> err=1.
